// File: rtl/gumnut_pkg.sv
// ----------------------------------------------------------------------------
// gumnut_pkg
// Shared definitions for the Gumnut core slice:
//   - ALU / shift / memory function codes
//   - instruction register field offsets
//   - register-file geometry
//   - the writeback request struct and the writeback FSM state type
// No ports (package).
// ----------------------------------------------------------------------------
package gumnut_pkg;

    // Register-file geometry
    localparam int GPR_COUNT  = 8;
    localparam int GPR_DATA_W = 8;
    localparam int GPR_AW     = 3;

    // ALU function codes
    localparam logic [2:0] ALU_FN_ADD  = 3'd0;
    localparam logic [2:0] ALU_FN_ADDC = 3'd1;
    localparam logic [2:0] ALU_FN_SUB  = 3'd2;
    localparam logic [2:0] ALU_FN_SUBC = 3'd3;
    localparam logic [2:0] ALU_FN_AND  = 3'd4;
    localparam logic [2:0] ALU_FN_OR   = 3'd5;
    localparam logic [2:0] ALU_FN_XOR  = 3'd6;
    localparam logic [2:0] ALU_FN_MASK = 3'd7;

    // Shift function codes
    localparam logic [1:0] SHIFT_FN_SHL = 2'd0;
    localparam logic [1:0] SHIFT_FN_SHR = 2'd1;
    localparam logic [1:0] SHIFT_FN_ROL = 2'd2;
    localparam logic [1:0] SHIFT_FN_ROR = 2'd3;

    // Memory / IO function codes
    localparam logic [1:0] MEM_FN_LDM = 2'd0;
    localparam logic [1:0] MEM_FN_STM = 2'd1;
    localparam logic [1:0] MEM_FN_INP = 2'd2;
    localparam logic [1:0] MEM_FN_OUT = 2'd3;

    // Instruction register field offsets (LSB of each 3-bit register field)
    localparam int IR_RD_LSB = 11;
    localparam int IR_RS_LSB = 8;
    localparam int IR_R2_LSB = 5;

    // One writeback request as presented by the ALU stage
    typedef struct packed {
        logic [GPR_AW-1:0]     rd;
        logic [GPR_DATA_W-1:0] data;
        logic                  c;
        logic                  we;
        logic                  cc_we;
        logic                  save;
        logic                  restore;
    } wb_req_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_HOLD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/gumnut_gpr_file.sv
// ----------------------------------------------------------------------------
// gumnut_gpr_file
// General-purpose register file: NUM_GPR x DATA_W, one synchronous write
// port, two combinational read ports. r0 is hard-wired to zero: writes to it
// are dropped and reads of it return 0.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset (clears all)
//   i_we, i_waddr, i_wdata write port
//   i_raddr_a, o_rdata_a  read port A
//   i_raddr_b, o_rdata_b  read port B
// ----------------------------------------------------------------------------
module gumnut_gpr_file
    import gumnut_pkg::*;
#(
    parameter int NUM_GPR = GPR_COUNT,
    parameter int DATA_W  = GPR_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [GPR_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [GPR_AW-1:0] i_raddr_a,
    input  logic [GPR_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [NUM_GPR];

    // NOTE: the array is reset because the architecture defines every GPR as
    // zero after reset; without that requirement a memory is better left
    // unreset so it can map onto RAM/LUT storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/gumnut_writeback.sv
// ----------------------------------------------------------------------------
// gumnut_writeback
// Writeback stage after the Gumnut ALU. Commits results to the GPR file and
// the Z/C condition codes, holds one request while the core stalls, and
// saves/restores flags on interrupt entry / reti.
// Configuration macro: GUMNUT_WB_BYPASS_EN -- when defined, read ports and
// flags forward the commit happening this cycle (r0 never forwarded).
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_wb_valid / o_wb_ready           request handshake
//   i_wb_rd, i_wb_data, i_wb_c        destination, result, ALU carry
//   i_wb_we, i_wb_cc_we               GPR write enable, flag write enable
//   i_wb_save, i_wb_restore           flag save (irq entry) / restore (reti)
//   i_stall                           core stall, blocks commit
//   i_rs_addr/o_rs_data, i_r2_addr/o_r2_data  combinational read ports
//   o_cc_z, o_cc_c                    condition codes
//   o_pending                         a request is held
// ----------------------------------------------------------------------------
module gumnut_writeback
    import gumnut_pkg::*;
#(
    parameter int NUM_GPR = GPR_COUNT,
    parameter int DATA_W  = GPR_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wb_valid,
    output logic              o_wb_ready,
    input  logic [GPR_AW-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_wb_c,
    input  logic              i_wb_we,
    input  logic              i_wb_cc_we,
    input  logic              i_wb_save,
    input  logic              i_wb_restore,
    input  logic              i_stall,
    input  logic [GPR_AW-1:0] i_rs_addr,
    input  logic [GPR_AW-1:0] i_r2_addr,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_r2_data,
    output logic              o_cc_z,
    output logic              o_cc_c,
    output logic              o_pending
);

    wb_state_e         r_state;
    wb_state_e         w_state_next;
    wb_req_t           r_hold;
    wb_req_t           w_in_req;
    wb_req_t           w_req;
    logic              w_commit;
    logic              w_hold_load;
    logic              r_z, r_c;
    logic [1:0]        r_saved;      // {Z, C}
    logic              w_next_z, w_next_c;
    logic [1:0]        w_next_saved;
    logic [DATA_W-1:0] w_rs_raw, w_r2_raw;

    always_comb begin
        w_in_req         = '0;
        w_in_req.rd      = i_wb_rd;
        w_in_req.data    = i_wb_data;
        w_in_req.c       = i_wb_c;
        w_in_req.we      = i_wb_we;
        w_in_req.cc_we   = i_wb_cc_we;
        w_in_req.save    = i_wb_save;
        w_in_req.restore = i_wb_restore;
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WB_IDLE: if (i_wb_valid && i_stall) w_state_next = WB_HOLD;
            WB_HOLD: if (!i_stall)              w_state_next = WB_IDLE;
            default:                            w_state_next = WB_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // In IDLE wb_ready is 1, so wb_valid alone means a transfer.
    always_comb begin
        o_wb_ready  = 1'b0;
        o_pending   = 1'b0;
        w_commit    = 1'b0;
        w_hold_load = 1'b0;
        case (r_state)
            WB_IDLE: begin
                o_wb_ready  = 1'b1;
                w_commit    = i_wb_valid && !i_stall;
                w_hold_load = i_wb_valid && i_stall;
            end
            WB_HOLD: begin
                o_pending = 1'b1;
                w_commit  = !i_stall;
            end
            default: ;
        endcase
    end

    // Held request is frozen from the transfer edge until it commits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_hold_load) begin
            r_hold <= w_in_req;
        end
    end

    assign w_req = (r_state == WB_HOLD) ? r_hold : w_in_req;

    // ---------------- condition codes ----------------
    // Restore beats cc_we; save always captures the pre-commit flags, so
    // save+restore together swaps live and saved flags.
    always_comb begin
        w_next_z     = r_z;
        w_next_c     = r_c;
        w_next_saved = r_saved;
        if (w_commit) begin
            if (w_req.restore) begin
                {w_next_z, w_next_c} = r_saved;
            end else if (w_req.cc_we) begin
                w_next_z = (w_req.data == '0);
                w_next_c = w_req.c;
            end
            if (w_req.save) begin
                w_next_saved = {r_z, r_c};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_saved <= 2'b00;
        end else begin
            r_z     <= w_next_z;
            r_c     <= w_next_c;
            r_saved <= w_next_saved;
        end
    end

    // ---------------- register file ----------------
    gumnut_gpr_file #(
        .NUM_GPR (NUM_GPR),
        .DATA_W  (DATA_W)
    ) u_gpr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_we      (w_commit && w_req.we),
        .i_waddr   (w_req.rd),
        .i_wdata   (w_req.data),
        .i_raddr_a (i_rs_addr),
        .i_raddr_b (i_r2_addr),
        .o_rdata_a (w_rs_raw),
        .o_rdata_b (w_r2_raw)
    );

`ifdef GUMNUT_WB_BYPASS_EN
    // Write-through forwarding of this cycle's commit; rd==0 never forwards.
    logic w_fwd;
    assign w_fwd     = w_commit && w_req.we && (w_req.rd != '0);
    assign o_rs_data = (w_fwd && (w_req.rd == i_rs_addr)) ? w_req.data : w_rs_raw;
    assign o_r2_data = (w_fwd && (w_req.rd == i_r2_addr)) ? w_req.data : w_r2_raw;
    assign o_cc_z    = w_next_z;
    assign o_cc_c    = w_next_c;
`else
    assign o_rs_data = w_rs_raw;
    assign o_r2_data = w_r2_raw;
    assign o_cc_z    = r_z;
    assign o_cc_c    = r_c;
`endif

endmodule

// File: tb/tb_gumnut_writeback.sv
// ----------------------------------------------------------------------------
// tb_gumnut_writeback
// Directed testbench for gumnut_writeback. Expected values are hand-derived.
// Honours GUMNUT_WB_BYPASS_EN for the same-cycle forwarding expectations.
// ----------------------------------------------------------------------------
module tb_gumnut_writeback;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid;
    logic       wb_ready;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       wb_c, wb_we, wb_cc_we, wb_save, wb_restore;
    logic       stall;
    logic [2:0] rs_addr, r2_addr;
    logic [7:0] rs_data, r2_data;
    logic       cc_z, cc_c;
    logic       pending;

    int n_vec = 0;
    int n_bad = 0;

`ifdef GUMNUT_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    gumnut_writeback dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wb_valid   (wb_valid),
        .o_wb_ready   (wb_ready),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .i_wb_c       (wb_c),
        .i_wb_we      (wb_we),
        .i_wb_cc_we   (wb_cc_we),
        .i_wb_save    (wb_save),
        .i_wb_restore (wb_restore),
        .i_stall      (stall),
        .i_rs_addr    (rs_addr),
        .i_r2_addr    (r2_addr),
        .o_rs_data    (rs_data),
        .o_r2_data    (r2_data),
        .o_cc_z       (cc_z),
        .o_cc_c       (cc_c),
        .o_pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads one register through both ports and checks it.
    task automatic check_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        rs_addr = addr;
        r2_addr = addr;
        #1;
        check({tag, "_rs"}, rs_data, exp);
        check({tag, "_r2"}, r2_data, exp);
    endtask

    task automatic check_flags(input string tag, input logic z, input logic c);
        check({tag, "_z"}, cc_z, z);
        check({tag, "_c"}, cc_c, c);
    endtask

    task automatic drive(input logic [2:0] rd, input logic [7:0] data, input logic c,
                         input logic we, input logic cc_we, input logic save, input logic restore);
        wb_rd      = rd;
        wb_data    = data;
        wb_c       = c;
        wb_we      = we;
        wb_cc_we   = cc_we;
        wb_save    = save;
        wb_restore = restore;
        wb_valid   = 1'b1;
    endtask

    task automatic idle();
        wb_valid   = 1'b0;
        wb_we      = 1'b0;
        wb_cc_we   = 1'b0;
        wb_save    = 1'b0;
        wb_restore = 1'b0;
    endtask

    // One unstalled transfer; its effects are visible after the edge.
    task automatic send(input logic [2:0] rd, input logic [7:0] data, input logic c,
                        input logic we, input logic cc_we, input logic save, input logic restore);
        drive(rd, data, c, we, cc_we, save, restore);
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; rs_addr = '0; r2_addr = '0;
        wb_rd = '0; wb_data = '0; wb_c = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1. Reset state
        check("rst_ready", wb_ready, 1'b1);
        check("rst_pending", pending, 1'b0);
        check_flags("rst", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_reg($sformatf("rst_gpr%0d", i), 3'(i), 8'h00);
            tick();
        end

        // 2. rd=3 A5 with carry
        send(3'd3, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_reg("w3", 3'd3, 8'hA5);
        check_flags("w3", 1'b0, 1'b1);

        // 3. r0 write dropped, flags still follow data FF / c=0
        send(3'd0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_reg("w0", 3'd0, 8'h00);
        check_flags("w0", 1'b0, 1'b0);
        check_reg("w0_keep3", 3'd3, 8'hA5);

        // 4. Stalled commit of rd=5 data=00, held for 3 cycles
        send(3'd5, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        drive(3'd5, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        // Source now presents a different request; it must not disturb the held one.
        drive(3'd6, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold%0d_pending", k), pending, 1'b1);
            check($sformatf("hold%0d_ready", k), wb_ready, 1'b0);
            check_reg($sformatf("hold%0d_gpr5", k), 3'd5, 8'h5A);
            check($sformatf("hold%0d_z", k), cc_z, 1'b0);
            if (k < 2) tick();
        end
        stall = 1'b0;
        tick();
        check("rel_pending", pending, 1'b0);
        check_reg("rel_gpr5", 3'd5, 8'h00);
        check_flags("rel", 1'b1, 1'b0);
        tick();
        idle();
        check_reg("next_gpr6", 3'd6, 8'h77);
        check_flags("next", 1'b1, 1'b0);

        // 5. Save / restore
        send(3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // Z1 C0
        check_flags("sr_set", 1'b1, 1'b0);
        send(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // saved = 10
        send(3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // Z0 C1
        check_flags("sr_mod", 1'b0, 1'b1);
        send(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // restore -> Z1 C0
        check_flags("sr_restore", 1'b1, 1'b0);
        send(3'd0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // Z0 C1
        send(3'd0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);   // restore beats cc_we
        check_flags("sr_prio", 1'b1, 1'b0);
        send(3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);   // Z0 C1
        send(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);   // swap: saved=01, ZC=10
        check_flags("sr_swap", 1'b1, 1'b0);
        send(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // restore -> Z0 C1
        check_flags("sr_swap_back", 1'b0, 1'b1);

        // 6. Same-cycle read of a register being committed
        send(3'd2, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rs_addr = 3'd2;
        r2_addr = 3'd2;
        drive(3'd2, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // next flags Z0 C0
        #1;
        check("fwd_rs", rs_data, BYPASS ? 8'h3C : 8'h11);
        check("fwd_c", cc_c, BYPASS ? 1'b0 : 1'b1);
        tick();
        idle();
        check_reg("fwd_after", 3'd2, 8'h3C);
        check("fwd_after_c", cc_c, 1'b0);

        // Reset while a request is held: nothing from it commits.
        stall = 1'b1;
        drive(3'd4, 8'h42, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        check("rsth_pending", pending, 1'b1);
        rst = 1'b1;
        stall = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        check("rsth_pending_clr", pending, 1'b0);
        check("rsth_ready", wb_ready, 1'b1);
        check_reg("rsth_gpr4", 3'd4, 8'h00);
        check_reg("rsth_gpr2", 3'd2, 8'h00);
        check_flags("rsth", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
